// File: rtl/disp_pkg.sv
// Shared display-path definitions: frame geometry, frame-buffer bank bases and the
// read-scheduler FSM encoding.
package disp_pkg;

    localparam int unsigned H_DISP           = 1280;
    localparam int unsigned V_DISP           = 720;
    localparam int unsigned FRAME_WORDS_DFLT = H_DISP * V_DISP;
    localparam int unsigned BURST_LEN_DFLT   = 256;
    localparam int unsigned FIFO_DEPTH_DFLT  = 1024;
    localparam int unsigned ADDR_W_DFLT      = 24;

    localparam logic [23:0] BANK0_BASE = 24'h000000;
    localparam logic [23:0] BANK1_BASE = 24'h100000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        XFER,
        DONE
    } rd_state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fb_rd_scheduler.sv
// Frame-buffer read scheduler: picks the newest completed camera bank at display frame
// start, flushes the display FIFO and issues burst reads whenever a whole burst fits.
module fb_rd_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned       FRAME_WORDS = FRAME_WORDS_DFLT,
    parameter int unsigned       BURST_LEN   = BURST_LEN_DFLT,
    parameter int unsigned       FIFO_DEPTH  = FIFO_DEPTH_DFLT,
    parameter int unsigned       ADDR_W      = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(BANK1_BASE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          wr_frame_done,
    input  logic                          wr_frame_bank,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_usedw,
    output logic                          rd_req,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [$clog2(BURST_LEN):0]    rd_len,
    input  logic                          rd_ack,
    input  logic                          rd_valid,
    output logic                          rd_bank,
    output logic                          fifo_clr,
    output logic                          frame_rd_done,
    output logic                          busy
);

    localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);

    rd_state_e         state_q, state_d;
    logic              last_bank_q, last_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              restart_pend_q, restart_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic              fifo_clr_q, fifo_clr_d;
    logic              frame_rd_done_q, frame_rd_done_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]  remain;
    logic [LEN_W-1:0]  len;
    logic              space_ok;
    logic [LEN_W-1:0]  beat_inc;
    logic [CNT_W-1:0]  word_sum;
    logic [ADDR_W-1:0] bank_base;
    logic              do_restart;

    // The last burst of a frame is shortened to what is left; a burst is only requested
    // once all of it fits in the FIFO, so the FIFO can never overflow.
    assign remain    = CNT_W'(FRAME_WORDS) - word_cnt_q;
    assign len       = LEN_W'(min_u(32'(remain), BURST_LEN));
    assign space_ok  = (32'(fifo_usedw) + 32'(len)) <= FIFO_DEPTH;
    assign beat_inc  = beat_cnt_q + LEN_W'(1);
    assign word_sum  = word_cnt_q + CNT_W'(rd_len_q);
    assign bank_base = rd_bank_q ? BANK_OFFSET : ADDR_W'(BANK0_BASE);

    // A completion reported in the same cycle as frame start is already visible here,
    // which gives the bypass onto rd_bank for free.
    assign last_bank_d = wr_frame_done ? wr_frame_bank : last_bank_q;

    always_comb begin
        // NOTE: every next-state value gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        rd_bank_d       = rd_bank_q;
        word_cnt_d      = word_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        restart_pend_d  = restart_pend_q;
        rd_addr_d       = rd_addr_q;
        rd_len_d        = rd_len_q;
        busy_d          = busy_q;
        fifo_clr_d      = 1'b0;
        frame_rd_done_d = 1'b0;
        do_restart      = 1'b0;

        case (state_q)
            IDLE, DONE: do_restart = frame_start;
            WAIT_SPACE: begin
                if (frame_start) begin
                    do_restart = 1'b1;
                end else if (space_ok) begin
                    state_d   = REQ;
                    rd_addr_d = bank_base + ADDR_W'(word_cnt_q);
                    rd_len_d  = len;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    state_d        = XFER;
                    beat_cnt_d     = '0;
                    restart_pend_d = frame_start;
                end else if (frame_start) begin
                    do_restart = 1'b1;
                end
            end
            XFER: begin
                if (frame_start) restart_pend_d = 1'b1;
                if (rd_valid) begin
                    beat_cnt_d = beat_inc;
                    if (beat_inc == rd_len_q) begin
                        word_cnt_d = word_sum;
                        if (restart_pend_q || frame_start) begin
                            do_restart = 1'b1;
                        end else if (word_sum == CNT_W'(FRAME_WORDS)) begin
                            frame_rd_done_d = 1'b1;
                            busy_d          = 1'b0;
                            state_d         = DONE;
                        end else begin
                            state_d = WAIT_SPACE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_restart) begin
            state_d        = WAIT_SPACE;
            rd_bank_d      = last_bank_d;
            word_cnt_d     = '0;
            restart_pend_d = 1'b0;
            busy_d         = 1'b1;
            fifo_clr_d     = 1'b1;
        end
    end

    // NOTE: non-blocking assignments here so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            last_bank_q     <= 1'b0;
            rd_bank_q       <= 1'b0;
            word_cnt_q      <= '0;
            beat_cnt_q      <= '0;
            restart_pend_q  <= 1'b0;
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            fifo_clr_q      <= 1'b0;
            frame_rd_done_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_bank_q     <= last_bank_d;
            rd_bank_q       <= rd_bank_d;
            word_cnt_q      <= word_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            restart_pend_q  <= restart_pend_d;
            rd_addr_q       <= rd_addr_d;
            rd_len_q        <= rd_len_d;
            fifo_clr_q      <= fifo_clr_d;
            frame_rd_done_q <= frame_rd_done_d;
            busy_q          <= busy_d;
        end
    end

    assign rd_req        = (state_q == REQ);
    assign rd_addr       = rd_addr_q;
    assign rd_len        = rd_len_q;
    assign rd_bank       = rd_bank_q;
    assign fifo_clr      = fifo_clr_q;
    assign frame_rd_done = frame_rd_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fb_rd_scheduler.sv
// Self-checking bench for fb_rd_scheduler: a table of whole-frame scenarios, hand-written
// restart/reset sequences and randomized frames against a burst-list reference model.
module tb_fb_rd_scheduler;

    localparam int          FW   = 1000;
    localparam int          BL   = 256;
    localparam int          FD   = 1024;
    localparam int          AW   = 24;
    localparam logic [23:0] BOFF = 24'h100000;
    localparam int          UW   = $clog2(FD) + 1;
    localparam int          LW   = $clog2(BL) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start, wr_frame_done, wr_frame_bank, rd_ack, rd_valid;
    logic [UW-1:0] fifo_usedw;
    logic          rd_req, rd_bank, fifo_clr, frame_rd_done, busy;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] rd_len;

    int   errors = 0;
    int   checks = 0;
    logic model_last_bank = 1'b0;

    fb_rd_scheduler #(
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD),
        .ADDR_W     (AW),
        .BANK_OFFSET(BOFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .wr_frame_done(wr_frame_done),
        .wr_frame_bank(wr_frame_bank),
        .fifo_usedw   (fifo_usedw),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_bank      (rd_bank),
        .fifo_clr     (fifo_clr),
        .frame_rd_done(frame_rd_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    typedef struct {
        bit          pre_wd;
        logic        pre_bank;
        bit          same_wd;
        logic        same_bank;
        int          ack_delay;
        bit          rnd;
        logic        exp_bank;
        logic [23:0] exp_first;
        int          exp_bursts;
        int          exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start   = 1'b0;
        wr_frame_done = 1'b0;
        rd_ack        = 1'b0;
        rd_valid      = 1'b0;
    endtask

    task automatic pulse_wd(input logic bank);
        idle_inputs();
        wr_frame_done   = 1'b1;
        wr_frame_bank   = bank;
        model_last_bank = bank;
        tick();
        idle_inputs();
    endtask

    // Pulses frame_start (optionally with a same-cycle write completion) and checks the
    // flush pulse, busy and the latched bank; leaves two cycles after the pulse.
    task automatic start_frame(input bit wd, input logic wb, input logic exp_bank);
        idle_inputs();
        frame_start = 1'b1;
        if (wd) begin
            wr_frame_done   = 1'b1;
            wr_frame_bank   = wb;
            model_last_bank = wb;
        end
        tick();
        idle_inputs();
        check("start_fifo_clr", fifo_clr, 1);
        check("start_busy", busy, 1);
        check("start_bank", rd_bank, exp_bank);
        check("start_no_req", rd_req, 0);
        tick();
        check("clr_one_pulse", fifo_clr, 0);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!rd_req && n < 50) begin
            idle_inputs();
            tick();
            n++;
        end
        check(name, rd_req, 1);
    endtask

    // Acts as the memory controller for one frame and checks every request against the
    // burst list the frame should produce: bursts of min(BL, remaining) from the bank base.
    task automatic run_frame(input logic exp_bank, input int ack_delay, input bit rnd,
                             input bit noise, output int n_bursts, output int last_len,
                             output logic [23:0] first_addr);
        int            w, beats_left, held, exp_len, prev_used, budget;
        logic [AW-1:0] exp_addr;
        logic          prev_req;
        bit            expect_done, done;
        w = 0; beats_left = 0; held = 0; exp_len = 0; exp_addr = '0;
        prev_used = int'(fifo_usedw); prev_req = 1'b0; expect_done = 0; done = 0;
        budget = 20000; n_bursts = 0; last_len = 0; first_addr = '0;
        while (!done && budget > 0) begin
            idle_inputs();
            if (beats_left > 0) begin
                if (rd_req) check("req_during_burst", rd_req, 0);
                rd_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (rd_valid) begin
                    beats_left--;
                    if (beats_left == 0) begin
                        w          += exp_len;
                        last_len    = exp_len;
                        expect_done = (w == FW);
                    end
                end
            end else if (rd_req) begin
                if (!prev_req) begin
                    exp_len  = (FW - w < BL) ? FW - w : BL;
                    exp_addr = (exp_bank ? BOFF : 24'h0) + AW'(w);
                    check("req_addr", rd_addr, exp_addr);
                    check("req_len", rd_len, exp_len);
                    check("req_bank", rd_bank, exp_bank);
                    check("req_fits", (prev_used + int'(rd_len)) <= FD, 1);
                    if (n_bursts == 0) first_addr = rd_addr;
                    n_bursts++;
                    held = 0;
                end else begin
                    check("hold_addr", rd_addr, exp_addr);
                    check("hold_len", rd_len, exp_len);
                end
                if (held == ack_delay) begin
                    rd_ack     = 1'b1;
                    beats_left = exp_len;
                end
                held++;
            end else if (noise) begin
                rd_valid = 1'($urandom_range(0, 1));
            end
            if (noise && $urandom_range(0, 40) == 0) begin
                wr_frame_done   = 1'b1;
                wr_frame_bank   = 1'($urandom_range(0, 1));
                model_last_bank = wr_frame_bank;
            end
            fifo_usedw = rnd ? UW'($urandom_range(0, FD)) : '0;
            prev_used  = int'(fifo_usedw);
            prev_req   = rd_req;
            tick();
            budget--;
            if (expect_done) begin
                check("frame_rd_done", frame_rd_done, 1);
                check("busy_drop", busy, 0);
                done = 1;
            end else begin
                check("no_early_done", frame_rd_done, 0);
                check("busy_in_frame", busy, 1);
                check("no_stray_clr", fifo_clr, 0);
            end
        end
        check("frame_timeout", done, 1);
        idle_inputs();
        fifo_usedw = '0;
        tick();
        check("done_one_pulse", frame_rd_done, 0);
        check("idle_after_done", busy, 0);
        check("no_req_after_done", rd_req, 0);
        check("bank_held", rd_bank, exp_bank);
    endtask

    vec_t        vecs[6];
    int          nb, ll;
    logic [23:0] fa;
    logic        wd, wb, eb;

    initial begin
        vecs[0] = '{0, 1'b0, 0, 1'b0, 1, 0, 1'b0, 24'h000000, 4, 232};
        vecs[1] = '{1, 1'b1, 0, 1'b0, 0, 0, 1'b1, 24'h100000, 4, 232};
        vecs[2] = '{0, 1'b0, 1, 1'b0, 1, 0, 1'b0, 24'h000000, 4, 232};
        vecs[3] = '{0, 1'b0, 0, 1'b0, 5, 0, 1'b0, 24'h000000, 4, 232};
        vecs[4] = '{1, 1'b1, 0, 1'b0, 2, 1, 1'b1, 24'h100000, 4, 232};
        vecs[5] = '{1, 1'b1, 1, 1'b0, 0, 1, 1'b0, 24'h000000, 4, 232};

        idle_inputs();
        wr_frame_bank = 1'b0;
        fifo_usedw    = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_len", rd_len, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_fifo_clr", fifo_clr, 0);
        check("rst_frame_rd_done", frame_rd_done, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre_wd) pulse_wd(vecs[i].pre_bank);
            fifo_usedw = '0;
            start_frame(vecs[i].same_wd, vecs[i].same_bank, vecs[i].exp_bank);
            run_frame(vecs[i].exp_bank, vecs[i].ack_delay, vecs[i].rnd, 0, nb, ll, fa);
            check("vec_bursts", nb, vecs[i].exp_bursts);
            check("vec_last_len", ll, vecs[i].exp_last);
            check("vec_first_addr", fa, vecs[i].exp_first);
        end

        // FIFO too full for a full burst, then exactly enough room.
        fifo_usedw = UW'(800);
        start_frame(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("a_no_req_800", rd_req, 0);
        end
        fifo_usedw = UW'(768);
        tick();
        check("a_req_at_768", rd_req, 1);
        check("a_len_768", rd_len, 256);
        run_frame(1'b0, 0, 0, 0, nb, ll, fa);
        check("a_bursts", nb, 4);

        // Frame start 100 beats into a burst: burst drains, then restart from the new bank.
        fifo_usedw = '0;
        start_frame(1, 1'b0, 1'b0);
        wait_req("b_req");
        check("b_addr", rd_addr, 0);
        idle_inputs();
        rd_ack = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            idle_inputs();
            rd_valid = 1'b1;
            tick();
        end
        idle_inputs();
        frame_start = 1'b1;
        tick();
        check("b_no_clr_at_fs", fifo_clr, 0);
        for (int i = 0; i < 156; i++) begin
            idle_inputs();
            rd_valid = 1'b1;
            if (i == 0) begin
                wr_frame_done   = 1'b1;
                wr_frame_bank   = 1'b1;
                model_last_bank = 1'b1;
            end
            tick();
            if (i < 155) begin
                check("b_no_clr", fifo_clr, 0);
                check("b_no_done", frame_rd_done, 0);
                check("b_bank_held", rd_bank, 0);
            end
        end
        idle_inputs();
        check("b_restart_clr", fifo_clr, 1);
        check("b_restart_no_done", frame_rd_done, 0);
        check("b_new_bank", rd_bank, 1);
        check("b_busy", busy, 1);
        tick();
        check("b_req_after", rd_req, 1);
        check("b_addr_base", rd_addr, BOFF);
        check("b_len_after", rd_len, 256);
        run_frame(1'b1, 0, 0, 0, nb, ll, fa);
        check("b_bursts", nb, 4);

        // Frame start while a request is pending and not yet acknowledged.
        start_frame(1, 1'b0, 1'b0);
        wait_req("c_req");
        idle_inputs();
        frame_start = 1'b1;
        tick();
        idle_inputs();
        check("c_withdrawn", rd_req, 0);
        check("c_clr", fifo_clr, 1);
        tick();
        check("c_req_again", rd_req, 1);
        check("c_addr_base", rd_addr, 0);
        run_frame(1'b0, 1, 0, 0, nb, ll, fa);
        check("c_bursts", nb, 4);

        // Acknowledge and frame start in the same cycle: the ack wins.
        start_frame(1, 1'b1, 1'b1);
        wait_req("d_req");
        idle_inputs();
        rd_ack      = 1'b1;
        frame_start = 1'b1;
        tick();
        check("d_req_dropped", rd_req, 0);
        check("d_no_clr", fifo_clr, 0);
        for (int i = 0; i < 256; i++) begin
            idle_inputs();
            rd_valid = 1'b1;
            tick();
            if (i < 255) check("d_no_clr_burst", fifo_clr, 0);
        end
        idle_inputs();
        check("d_restart_clr", fifo_clr, 1);
        check("d_no_done", frame_rd_done, 0);
        tick();
        check("d_req_base", rd_addr, BOFF);
        run_frame(1'b1, 0, 0, 0, nb, ll, fa);
        check("d_bursts", nb, 4);

        // Asynchronous reset in the middle of a burst.
        start_frame(1, 1'b1, 1'b1);
        wait_req("e_req");
        idle_inputs();
        rd_ack = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            rd_valid = 1'b1;
            tick();
        end
        check("e_bank_before", rd_bank, 1);
        check("e_busy_before", busy, 1);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("e_rst_rd_req", rd_req, 0);
        check("e_rst_rd_addr", rd_addr, 0);
        check("e_rst_rd_len", rd_len, 0);
        check("e_rst_rd_bank", rd_bank, 0);
        check("e_rst_fifo_clr", fifo_clr, 0);
        check("e_rst_done", frame_rd_done, 0);
        check("e_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        model_last_bank = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            rd_valid = 1'b1;
            tick();
            check("e_stray_no_req", rd_req, 0);
            check("e_stray_no_busy", busy, 0);
        end
        start_frame(0, 1'b0, 1'b0);
        run_frame(1'b0, 1, 0, 0, nb, ll, fa);
        check("e_first_addr", fa, 0);
        check("e_bursts", nb, 4);

        // Randomized frames: FIFO level, ack latency, beat gaps and bank completions.
        for (int k = 0; k < 5; k++) begin
            wd = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            eb = wd ? wb : model_last_bank;
            fifo_usedw = '0;
            start_frame(wd, wb, eb);
            run_frame(eb, int'($urandom_range(0, 3)), 1, 1, nb, ll, fa);
            check("rnd_bursts", nb, 4);
            check("rnd_last_len", ll, 232);
            check("rnd_first_addr", fa, eb ? BOFF : 24'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
